// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing a two-digit 7-segment display between two
// byte producers. Optional build macro: SEG_LEADING_BLANK_EN.
module seg_display_arbiter #(
    parameter int HOLD_CYCLES       = 25_000_000,
    parameter int IDLE_BLANK_CYCLES = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Req0_DV,
    input  logic [7:0] i_Req0_Byte,
    output logic       o_Req0_Ready,
    input  logic       i_Req1_DV,
    input  logic [7:0] i_Req1_Byte,
    output logic       o_Req1_Ready,
    output logic [3:0] o_Upper_Nibble,
    output logic [3:0] o_Lower_Nibble,
    output logic       o_Upper_En,
    output logic       o_Lower_En,
    output logic       o_Owner,
    output logic       o_Busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [27:0] HOLD_LOAD = 28'(HOLD_CYCLES - 1);
    localparam logic [27:0] BLANK_AT  = 28'(IDLE_BLANK_CYCLES);
    localparam bit          BLANK_ON  = (IDLE_BLANK_CYCLES != 0);

    state_t      state, state_nxt;
    logic        pref, pref_nxt;
    logic        grant;
    logic        req_dv;
    logic [7:0]  req_byte;
    logic        xfer;
    logic        lead_en;
    logic [7:0]  disp, disp_nxt;
    logic        upper_en, upper_en_nxt;
    logic        lower_en, lower_en_nxt;
    logic        owner, owner_nxt;
    logic [27:0] hold_cnt, hold_nxt;
    logic [27:0] idle_cnt, idle_nxt;

    // Grant: a lone valid requester wins, otherwise the preferred one.
    always_comb begin
        grant = pref;
        if (i_Req0_DV && !i_Req1_DV) begin
            grant = 1'b0;
        end else if (!i_Req0_DV && i_Req1_DV) begin
            grant = 1'b1;
        end
    end

    assign req_dv   = grant ? i_Req1_DV : i_Req0_DV;
    assign req_byte = grant ? i_Req1_Byte : i_Req0_Byte;
    assign xfer     = (state == IDLE) && req_dv;

    assign o_Req0_Ready = (state == IDLE) && !grant;
    assign o_Req1_Ready = (state == IDLE) && grant;

`ifdef SEG_LEADING_BLANK_EN
    assign lead_en = (req_byte[7:4] != 4'h0);
`else
    assign lead_en = 1'b1;
`endif

    // Next-state: accept in IDLE, count down the hold, blank when idle.
    always_comb begin
        state_nxt    = state;
        pref_nxt     = pref;
        disp_nxt     = disp;
        upper_en_nxt = upper_en;
        lower_en_nxt = lower_en;
        owner_nxt    = owner;
        hold_nxt     = hold_cnt;
        idle_nxt     = idle_cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    disp_nxt     = req_byte;
                    owner_nxt    = grant;
                    pref_nxt     = ~grant;
                    hold_nxt     = HOLD_LOAD;
                    state_nxt    = HOLD;
                    upper_en_nxt = lead_en;
                    lower_en_nxt = 1'b1;
                    idle_nxt     = '0;
                end else begin
                    if (idle_cnt != '1) begin
                        idle_nxt = idle_cnt + 28'd1;
                    end
                    if (BLANK_ON && (idle_cnt == BLANK_AT)) begin
                        upper_en_nxt = 1'b0;
                        lower_en_nxt = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    hold_nxt = hold_cnt - 28'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state    <= IDLE;
            pref     <= 1'b0;
            disp     <= 8'h00;
            upper_en <= 1'b0;
            lower_en <= 1'b0;
            owner    <= 1'b0;
            hold_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pref     <= pref_nxt;
            disp     <= disp_nxt;
            upper_en <= upper_en_nxt;
            lower_en <= lower_en_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    assign o_Upper_Nibble = disp[7:4];
    assign o_Lower_Nibble = disp[3:0];
    assign o_Upper_En     = upper_en;
    assign o_Lower_En     = lower_en;
    assign o_Owner        = owner;
    assign o_Busy         = (state == HOLD);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: grant table, hold timing, blanking,
// round-robin alternation, mid-hold reset and leading-zero blanking.
module tb_seg_display_arbiter;

    localparam int H  = 4;
    localparam int IB = 3;

    logic       clk   = 1'b0;
    logic       rst_l = 1'b0;
    logic       dv0   = 1'b0;
    logic       dv1   = 1'b0;
    logic [7:0] b0    = 8'h00;
    logic [7:0] b1    = 8'h00;
    logic       r0, r1;
    logic [3:0] up, lo;
    logic       ue, le, own, busy;

    seg_display_arbiter #(
        .HOLD_CYCLES(H),
        .IDLE_BLANK_CYCLES(IB)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_l),
        .i_Req0_DV(dv0),
        .i_Req0_Byte(b0),
        .o_Req0_Ready(r0),
        .i_Req1_DV(dv1),
        .i_Req1_Byte(b1),
        .o_Req1_Ready(r1),
        .o_Upper_Nibble(up),
        .o_Lower_Nibble(lo),
        .o_Upper_En(ue),
        .o_Lower_En(le),
        .o_Owner(own),
        .o_Busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        logic       own;
        logic       ue;
        logic       le;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic dv0;
        logic dv1;
        logic r0;
        logic r1;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 100) begin
            step();
            k++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic send(input logic n, input logic [7:0] b,
                        input logic xue, input logic xle);
        int   k = 0;
        logic rdy;
        if (n) begin
            dv1 = 1'b1;
            b1  = b;
        end else begin
            dv0 = 1'b1;
            b0  = b;
        end
        #1;
        rdy = n ? r1 : r0;
        while (!rdy && k < 100) begin
            step();
            rdy = n ? r1 : r0;
            k++;
        end
        chk("send_ready", 32'(rdy), 32'd1);
        sbq.push_back('{b, n, xue, xle});
        step();
        if (n) dv1 = 1'b0;
        else dv0 = 1'b0;
    endtask

    // Scoreboard: each rise of busy presents one accepted byte.
    logic busy_prev = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (busy && !busy_prev) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h%0h expected none", up, lo);
            end else begin
                e = sbq.pop_front();
                chk("sb_byte", 32'({up, lo}), 32'(e.b));
                chk("sb_owner", 32'(own), 32'(e.own));
                chk("sb_upper_en", 32'(ue), 32'(e.ue));
                chk("sb_lower_en", 32'(le), 32'(e.le));
            end
        end
        busy_prev <= busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic xue;
        int   t_last;
        int   k;

        // grant table: rows 0..3 with pref=0, rows 4..7 with pref=1
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1};

        repeat (2) step();
        rst_l = 1'b1;
        step();
        chk("rst_upper_en", 32'(ue), 32'd0);
        chk("rst_lower_en", 32'(le), 32'd0);
        chk("rst_nibbles", 32'({up, lo}), 32'h00);
        chk("rst_ready0", 32'(r0), 32'd1);
        chk("rst_ready1", 32'(r1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(own), 32'd0);

        for (int i = 0; i < 4; i++) begin
            dv0 = tbl[i].dv0;
            dv1 = tbl[i].dv1;
            #1;
            chk($sformatf("grant_p0_r0_%0d", i), 32'(r0), 32'(tbl[i].r0));
            chk($sformatf("grant_p0_r1_%0d", i), 32'(r1), 32'(tbl[i].r1));
        end
        dv0 = 1'b0;
        dv1 = 1'b0;

        // hold timing for 0xA7 from requester 0
        step();
        send(1'b0, 8'hA7, 1'b1, 1'b1);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_nib", 32'({up, lo}), 32'hA7);
        for (int i = 1; i < H; i++) begin
            step();
            chk($sformatf("hold_ready_%0d", i), 32'(r0 | r1), 32'd0);
        end
        step();
        chk("hold_end_busy", 32'(busy), 32'd0);
        chk("hold_end_ready1", 32'(r1), 32'd1);

        for (int i = 4; i < 8; i++) begin
            dv0 = tbl[i].dv0;
            dv1 = tbl[i].dv1;
            #1;
            chk($sformatf("grant_p1_r0_%0d", i), 32'(r0), 32'(tbl[i].r0));
            chk($sformatf("grant_p1_r1_%0d", i), 32'(r1), 32'(tbl[i].r1));
        end
        dv0 = 1'b0;
        dv1 = 1'b0;

        // idle blanking: lit through 3 idle edges, dark on the 4th
        repeat (3) step();
        chk("blank_pre_en", 32'({ue, le}), 32'h3);
        step();
        chk("blank_en", 32'({ue, le}), 32'h0);
        chk("blank_nib_kept", 32'({up, lo}), 32'hA7);
        chk("blank_owner_kept", 32'(own), 32'd0);

        send(1'b0, 8'h3C, 1'b1, 1'b1);
        chk("relight_en", 32'({ue, le}), 32'h3);
        wait_idle("relight_idle");

        // alternation from pref=0 after reset
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        b0  = 8'h11;
        b1  = 8'h22;
        dv0 = 1'b1;
        dv1 = 1'b1;
        sbq.push_back('{8'h11, 1'b0, 1'b1, 1'b1});
        sbq.push_back('{8'h22, 1'b1, 1'b1, 1'b1});
        sbq.push_back('{8'h11, 1'b0, 1'b1, 1'b1});
        sbq.push_back('{8'h22, 1'b1, 1'b1, 1'b1});
        t_last = 0;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (!busy && k < 50) begin
                step();
                k++;
            end
            chk($sformatf("alt_rise_%0d", i), 32'(busy), 32'd1);
            if (i > 0) chk($sformatf("alt_gap_%0d", i), 32'(cyc - t_last), 32'(H + 1));
            t_last = cyc;
            if (i == 3) begin
                dv0 = 1'b0;
                dv1 = 1'b0;
            end
            k = 0;
            while (busy && k < 50) begin
                step();
                k++;
            end
            chk($sformatf("alt_fall_%0d", i), 32'(busy), 32'd0);
        end

        // reset in the middle of a hold with requester 1 still valid
        b1  = 8'h5A;
        dv1 = 1'b1;
        sbq.push_back('{8'h5A, 1'b1, 1'b1, 1'b1});
        k = 0;
        while (!busy && k < 50) begin
            step();
            k++;
        end
        chk("mid_busy", 32'(busy), 32'd1);
        step();
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_en", 32'({ue, le}), 32'h0);
        chk("mid_rst_nib", 32'({up, lo}), 32'h00);
        chk("mid_rst_owner", 32'(own), 32'd0);
        chk("mid_rst_ready1", 32'(r1), 32'd1);
        chk("mid_rst_ready0", 32'(r0), 32'd0);
        dv0 = 1'b1;
        #1;
        chk("mid_rst_pref0", 32'(r0), 32'd1);
        dv0 = 1'b0;
        dv1 = 1'b0;
        step();

        // leading-zero digit for 0x05
`ifdef SEG_LEADING_BLANK_EN
        xue = 1'b0;
`else
        xue = 1'b1;
`endif
        send(1'b0, 8'h05, xue, 1'b1);
        chk("lead_upper_en", 32'(ue), 32'(xue));
        chk("lead_lower_en", 32'(le), 32'd1);
        wait_idle("lead_idle");
        step();
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
